// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the SNN image loader.
// Imported by the loader top and its pixel unpacker.
package snn_pkg;

    localparam int         NUM_PIXELS = 784;
    localparam logic [7:0] ASCII_BASE = 8'h30;

    typedef enum logic [2:0] {
        LOAD_WAIT,
        LOAD_WRITE,
        START,
        WAIT_CORE,
        TX,
        TX_WAIT
    } loader_state_t;

endpackage

// File: rtl/pixel_unpacker.sv
// Byte shift register that serialises one pixel byte LSB-first.
// Reports the current bit and whether it is the eighth of the byte.
module pixel_unpacker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_shift,
    output logic       o_bit,
    output logic       o_last_bit
);

    logic [7:0] r_shreg;
    logic [2:0] r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= 8'h00;
            r_bit_cnt <= 3'd0;
        end else if (i_load) begin
            r_shreg   <= i_data;
            r_bit_cnt <= 3'd0;
        end else if (i_shift) begin
            r_shreg   <= {1'b0, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    assign o_bit      = r_shreg[0];
    assign o_last_bit = (r_bit_cnt == 3'd7);

endmodule

// File: rtl/snn_image_loader.sv
// Loads one packed image into the input-unit RAM, starts snn_core,
// then returns the classified digit as ASCII over the UART.
module snn_image_loader #(
    parameter int         NUM_PIXELS = snn_pkg::NUM_PIXELS,
    parameter int         ADDR_W     = 10,
    parameter logic [7:0] ASCII_BASE = snn_pkg::ASCII_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_clr_rdy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_d,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy
);

    import snn_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

    loader_state_t     r_state;
    logic [ADDR_W-1:0] r_pix_cnt;
    logic              r_rx_clr_rdy;
    logic              r_ram_we;
    logic              r_core_start;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic              r_busy;

    logic w_load;
    logic w_shift;
    logic w_bit;
    logic w_last;
    logic w_core_phase;

    assign w_load  = (r_state == LOAD_WAIT) && rx_rdy;
    assign w_shift = (r_state == LOAD_WRITE);

    pixel_unpacker u_unpacker (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_data     (rx_data),
        .i_shift    (w_shift),
        .o_bit      (w_bit),
        .o_last_bit (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LOAD_WAIT;
            r_pix_cnt    <= '0;
            r_rx_clr_rdy <= 1'b0;
            r_ram_we     <= 1'b0;
            r_core_start <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
        end else begin
            r_rx_clr_rdy <= 1'b0;
            r_core_start <= 1'b0;
            r_tx_start   <= 1'b0;
            unique case (r_state)
                LOAD_WAIT: begin
                    if (rx_rdy) begin
                        r_rx_clr_rdy <= 1'b1;
                        r_ram_we     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= LOAD_WRITE;
                    end
                end
                LOAD_WRITE: begin
                    if (w_last) begin
                        r_ram_we <= 1'b0;
                        if (r_pix_cnt == LAST_PIX) begin
                            // Counter wraps here so it never passes the image end
                            r_pix_cnt    <= '0;
                            r_core_start <= 1'b1;
                            r_state      <= START;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= LOAD_WAIT;
                        end
                    end else begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                end
                START: begin
                    r_pix_cnt <= '0;
                    r_state   <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        r_tx_data  <= ASCII_BASE + {4'h0, core_digit};
                        r_tx_start <= 1'b1;
                        r_state    <= TX;
                    end
                end
                TX: begin
                    r_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= LOAD_WAIT;
                    end
                end
                default: begin
                    r_ram_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= LOAD_WAIT;
                end
            endcase
        end
    end

    // Once the image is complete the core owns the RAM address
    assign w_core_phase = (r_state == START)     ||
                          (r_state == WAIT_CORE) ||
                          (r_state == TX)        ||
                          (r_state == TX_WAIT);

    assign ram_addr   = w_core_phase ? core_addr : r_pix_cnt;
    assign ram_we     = r_ram_we;
    assign ram_d      = r_ram_we & w_bit;
    assign rx_clr_rdy = r_rx_clr_rdy;
    assign core_start = r_core_start;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign busy       = r_busy;

endmodule
